// File: rtl/sub_pkg.sv
// Shared types and constants for the 8-bit borrow-select subtractor pipeline.
// Optional feature macro: SUB_OVERFLOW_EN (adds signed-overflow sign bits to s1_t).
package sub_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Stage-1 payload: lower result plus both precomputed upper candidates
    typedef struct packed {
        nibble_t lo_diff;
        logic    lo_borrow;
        nibble_t up_diff0;
        logic    up_borrow0;
        nibble_t up_diff1;
        logic    up_borrow1;
`ifdef SUB_OVERFLOW_EN
        logic    a_msb;
        logic    b_msb;
`endif
    } s1_t;

endpackage : sub_pkg

// File: rtl/four_bit_subtractor.sv
// Combinational 4-bit subtractor: {Bout, diff} = A - B - Bin.
// Ports:
//   A, B  : 4-bit operands
//   Bin   : borrow in
//   diff  : 4-bit difference (mod 16)
//   Bout  : borrow out, 1 when A < B + Bin
module four_bit_subtractor
    import sub_pkg::*;
(
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin,
    output logic [3:0] diff,
    output logic       Bout
);

    logic [NIBBLE_W:0] wide;

    // One extra bit captures the borrow as the sign of the 5-bit result
    always_comb begin
        wide = {1'b0, A} - {1'b0, B} - (NIBBLE_W+1)'(Bin);
        diff = wide[NIBBLE_W-1:0];
        Bout = wide[NIBBLE_W];
    end

endmodule : four_bit_subtractor

// File: rtl/eight_bit_select_subtractor_pipe.sv
// Two-stage pipelined 8-bit borrow-select subtractor computing A - B - Bin,
// with valid/ready handshakes on both sides and full backpressure.
// Optional feature macro: SUB_OVERFLOW_EN (adds registered output_ovf).
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   A, B, Bin           : minuend, subtrahend, borrow in
//   in_valid / in_ready : input handshake (in_ready is combinational)
//   output_diff         : registered difference
//   output_Bout         : registered borrow out
//   out_valid/out_ready : output handshake
//   output_ovf          : registered signed overflow (SUB_OVERFLOW_EN only)
module eight_bit_select_subtractor_pipe
    import sub_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bin,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] output_diff,
    output logic       output_Bout,
    output logic       out_valid,
    input  logic       out_ready
`ifdef SUB_OVERFLOW_EN
    ,
    output logic       output_ovf
`endif
);

    s1_t     s1_d;
    s1_t     s1_q;
    logic    s1_valid;
    logic    s1_load;
    logic    s2_load;

    nibble_t lo_diff;
    logic    lo_borrow;
    nibble_t up_diff0;
    logic    up_borrow0;
    nibble_t up_diff1;
    logic    up_borrow1;

    nibble_t sel_up_diff;
    logic    sel_up_borrow;

    // Lower nibble with the real borrow in
    four_bit_subtractor u_sub_lo (
        .A    (A[3:0]),
        .B    (B[3:0]),
        .Bin  (Bin),
        .diff (lo_diff),
        .Bout (lo_borrow)
    );

    // Upper nibble assuming no borrow from the lower nibble
    four_bit_subtractor u_sub_up0 (
        .A    (A[7:4]),
        .B    (B[7:4]),
        .Bin  (1'b0),
        .diff (up_diff0),
        .Bout (up_borrow0)
    );

    // Upper nibble assuming a borrow from the lower nibble
    four_bit_subtractor u_sub_up1 (
        .A    (A[7:4]),
        .B    (B[7:4]),
        .Bin  (1'b1),
        .diff (up_diff1),
        .Bout (up_borrow1)
    );

    // Assemble the stage-1 payload
    always_comb begin
        s1_d            = '0;
        s1_d.lo_diff    = lo_diff;
        s1_d.lo_borrow  = lo_borrow;
        s1_d.up_diff0   = up_diff0;
        s1_d.up_borrow0 = up_borrow0;
        s1_d.up_diff1   = up_diff1;
        s1_d.up_borrow1 = up_borrow1;
`ifdef SUB_OVERFLOW_EN
        s1_d.a_msb      = A[7];
        s1_d.b_msb      = B[7];
`endif
    end

    // Pipeline advance: a stage loads when it is empty or its successor drains it
    always_comb begin
        s2_load  = !out_valid || out_ready;
        s1_load  = !s1_valid || s2_load;
        in_ready = s1_load;
    end

    // Lower borrow picks which precomputed upper candidate is correct
    always_comb begin
        sel_up_diff   = s1_q.lo_borrow ? s1_q.up_diff1   : s1_q.up_diff0;
        sel_up_borrow = s1_q.lo_borrow ? s1_q.up_borrow1 : s1_q.up_borrow0;
    end

    // Stage 1 register; valid clears when no new data arrives on a load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage 2 / output register; data holds while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            output_diff <= 8'h00;
            output_Bout <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                output_diff <= {sel_up_diff, s1_q.lo_diff};
                output_Bout <= sel_up_borrow;
            end
        end
    end

`ifdef SUB_OVERFLOW_EN
    // Overflow when operand signs differ and the result sign differs from A
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            output_ovf <= 1'b0;
        end else if (s2_load && s1_valid) begin
            output_ovf <= (s1_q.a_msb != s1_q.b_msb) && (sel_up_diff[3] != s1_q.a_msb);
        end
    end
`endif

endmodule : eight_bit_select_subtractor_pipe

// File: tb/tb_eight_bit_select_subtractor_pipe.sv
// Self-checking bench for eight_bit_select_subtractor_pipe: a scoreboard queue
// filled on every accepted input and drained by an independent output monitor.
module tb_eight_bit_select_subtractor_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] output_diff;
    logic       output_Bout;
    logic       out_valid;
    logic       out_ready;
`ifdef SUB_OVERFLOW_EN
    logic       output_ovf;
`endif

    eight_bit_select_subtractor_pipe dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .A           (A),
        .B           (B),
        .Bin         (Bin),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .output_diff (output_diff),
        .output_Bout (output_Bout),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef SUB_OVERFLOW_EN
        ,
        .output_ovf  (output_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       o;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_ready = 1'b0;
    bit   have_hold  = 1'b0;
    exp_t held;

    // Reference model: plain integer arithmetic
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int   r;
        exp_t e;
        r   = int'(a) - int'(b) - int'(bin);
        e.d = 8'(r);
        e.b = (r < 0);
`ifdef SUB_OVERFLOW_EN
        e.o = (a[7] != b[7]) && (e.d[7] != a[7]);
`else
        e.o = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp_t current();
        exp_t c;
        c.d = output_diff;
        c.b = output_Bout;
`ifdef SUB_OVERFLOW_EN
        c.o = output_ovf;
`else
        c.o = 1'b0;
`endif
        return c;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Input-side scoreboard push on every accepted transfer
    always @(negedge clk) begin
        if (reset_n && in_valid && in_ready) begin
            sb.push_back(model(A, B, Bin));
        end
    end

    // Output monitor: pop/compare on transfer, and check stability while stalled
    always @(negedge clk) begin
        if (!reset_n) begin
            have_hold = 1'b0;
        end else begin
            if (out_valid && have_hold) begin
                check("hold_stable", int'(current()), int'(held));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("result", int'(current()), int'(sb.pop_front()));
                end
                have_hold = 1'b0;
            end else if (out_valid) begin
                have_hold = 1'b1;
                held      = current();
            end else begin
                have_hold = 1'b0;
            end
        end
    end

    // Random downstream readiness when enabled
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin);
        bit done;
        done     = 1'b0;
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done     = 1'b1;
            end
        end
        if (!done) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        A         = 8'h00;
        B         = 8'h00;
        Bin       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_diff", int'(output_diff), 0);
        check("reset_bout", int'(output_Bout), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);

        // Basic latency and single-cycle valid
        send(8'h50, 8'h20, 1'b0);
        @(posedge clk);
        #1;
        check("lat_valid", int'(out_valid), 1);
        check("lat_diff", int'(output_diff), 8'h30);
        @(posedge clk);
        #1;
        check("lat_valid_clear", int'(out_valid), 0);

        // Directed borrow and select cases
        send(8'h00, 8'h01, 1'b0);
        send(8'h05, 8'h05, 1'b1);
        send(8'h10, 8'h01, 1'b0);
        send(8'h80, 8'h01, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        send(8'h7F, 8'h80, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: two accepts fill the pipe, third is refused
        out_ready = 1'b0;
        send(8'h03, 8'h01, 1'b0);
        send(8'h09, 8'h04, 1'b0);
        A        = 8'h20;
        B        = 8'h10;
        Bin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_diff", int'(output_diff), 8'h02);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h20, 8'h10, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Reset with both stages full
        out_ready = 1'b0;
        send(8'h44, 8'h11, 1'b0);
        send(8'h66, 8'h22, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_diff", int'(output_diff), 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;

        // Drain with a bounded wait
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        check("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_eight_bit_select_subtractor_pipe
